// File: rtl/brcomp_iter_pkg.sv
// Shared types and default sizing for the iterative branch comparator.
package brcomp_pkg;

    // Comparator sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } brcomp_state_e;

    // Default operand width and bits examined per cycle.
    localparam int BRCOMP_WIDTH_DEF = 32;
    localparam int BRCOMP_CHUNK_DEF = 8;

endpackage

// File: rtl/brcomp_iter_if.sv
// Request/result bundle between the register-file read stage and the
// iterative branch comparator. The comparator side uses the slave modport.
interface brcomp_iter_if
    import brcomp_pkg::*;
#(
    parameter int WIDTH = BRCOMP_WIDTH_DEF
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic             i_br_unsigned;
    logic             o_valid;
    logic             i_ready;
    logic             o_br_less;
    logic             o_br_equal;
    logic             o_busy;

    modport slave (
        input  i_valid, i_rs1_data, i_rs2_data, i_br_unsigned, i_ready,
        output o_ready, o_valid, o_br_less, o_br_equal, o_busy
    );

    modport master (
        output i_valid, i_rs1_data, i_rs2_data, i_br_unsigned, i_ready,
        input  o_ready, o_valid, o_br_less, o_br_equal, o_busy
    );
endinterface

// File: rtl/brcomp_iter_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module brcomp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

// File: rtl/brcomp_iter.sv
// Iterative branch comparator: compares two WIDTH-bit operands CHUNK bits
// per cycle, most significant chunk first, signed or unsigned.
// Optional build macro BRCOMP_EARLY_EXIT_EN: finish on the first differing
// chunk instead of always walking all chunks (results are identical).
module brcomp_iter
    import brcomp_pkg::*;
#(
    parameter int WIDTH = BRCOMP_WIDTH_DEF,
    parameter int CHUNK = BRCOMP_CHUNK_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    brcomp_iter_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    LAST_K   = KW'(N - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("brcomp_iter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    brcomp_state_e    state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [KW-1:0]    k_reg, k_next;
    logic             found_reg, found_next;   // an earlier chunk differed
    logic             lessw_reg, lessw_next;   // ordering of that first difference
    logic             less_reg, less_next;
    logic             equal_reg, equal_next;
    logic             valid_reg, ready_reg, busy_reg;

    // Operand slices, index 0 = most significant chunk.
    logic [CHUNK-1:0] a_chunks [N];
    logic [CHUNK-1:0] b_chunks [N];
    logic             chunk_lt, chunk_eq;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_chunks[gi] = a_reg[WIDTH-1-gi*CHUNK -: CHUNK];
            assign b_chunks[gi] = b_reg[WIDTH-1-gi*CHUNK -: CHUNK];
        end
    endgenerate

    brcomp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_chunks[k_reg]),
        .b  (b_chunks[k_reg]),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    logic diff_now, last_chunk, leave_cmp;

    // Next-state and datapath updates for the IDLE/CMP/DONE sequence.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        k_next     = k_reg;
        found_next = found_reg;
        lessw_next = lessw_reg;
        less_next  = less_reg;
        equal_next = equal_reg;
        diff_now   = 1'b0;
        last_chunk = 1'b0;
        leave_cmp  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.i_valid) begin
                    a_next     = bus.i_br_unsigned ? bus.i_rs1_data : (bus.i_rs1_data ^ MSB_MASK);
                    b_next     = bus.i_br_unsigned ? bus.i_rs2_data : (bus.i_rs2_data ^ MSB_MASK);
                    k_next     = '0;
                    found_next = 1'b0;
                    lessw_next = 1'b0;
                    less_next  = 1'b0;
                    equal_next = 1'b0;
                    state_next = CMP;
                end
            end
            CMP: begin
                diff_now   = !found_reg && !chunk_eq;
                last_chunk = (k_reg == LAST_K);
                if (diff_now) begin
                    found_next = 1'b1;
                    lessw_next = chunk_lt;
                end
`ifdef BRCOMP_EARLY_EXIT_EN
                leave_cmp = last_chunk || diff_now;
`else
                leave_cmp = last_chunk;
`endif
                if (leave_cmp) begin
                    state_next = DONE;
                    k_next     = '0;
                    less_next  = diff_now ? chunk_lt : lessw_reg;
                    equal_next = !(found_reg || diff_now);
                end else begin
                    k_next = k_reg + KW'(1);
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, operand, counter and result registers; handshake flags are
    // registered from the next state so every output comes from a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            k_reg     <= '0;
            found_reg <= 1'b0;
            lessw_reg <= 1'b0;
            less_reg  <= 1'b0;
            equal_reg <= 1'b0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            k_reg     <= k_next;
            found_reg <= found_next;
            lessw_reg <= lessw_next;
            less_reg  <= less_next;
            equal_reg <= equal_next;
            valid_reg <= (state_next == DONE);
            ready_reg <= (state_next == IDLE);
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign bus.o_valid    = valid_reg;
    assign bus.o_ready    = ready_reg;
    assign bus.o_busy     = busy_reg;
    assign bus.o_br_less  = less_reg;
    assign bus.o_br_equal = equal_reg;

endmodule

// File: tb/tb_brcomp_iter.sv
// Directed bench for brcomp_iter at WIDTH=32, CHUNK=8 (four chunks).
module tb_brcomp_iter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    brcomp_iter_if #(.WIDTH(32)) bus ();

    brcomp_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BRCOMP_EARLY_EXIT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = 4;
`endif

    // Issue one request and count cycles until o_valid (-1 on timeout).
    task automatic send_and_wait(input logic [31:0] a, input logic [31:0] b,
                                 input logic uns, output int lat);
        bus.i_rs1_data    = a;
        bus.i_rs2_data    = b;
        bus.i_br_unsigned = uns;
        bus.i_valid       = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.o_valid !== 1'b1) lat = -1;
    endtask

    task automatic consume();
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_br_less, bus.o_br_equal, bus.o_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 10000",
                     {bus.o_ready, bus.o_valid, bus.o_br_less, bus.o_br_equal, bus.o_busy});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset: outputs checked");
    endtask

    task automatic test_case(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic uns, input logic exp_less, input logic exp_eq,
                             input int exp_lat);
        int lat;
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before got %b want 1", name, bus.o_ready);
        end
        send_and_wait(a, b, uns, lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (bus.o_br_less !== exp_less || bus.o_br_equal !== exp_eq) begin
            errors++;
            $display("FAIL %s result got less=%b eq=%b want less=%b eq=%b",
                     name, bus.o_br_less, bus.o_br_equal, exp_less, exp_eq);
        end
        checks++;
        if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++; $display("FAIL %s done_flags got ready=%b busy=%b want 0 1",
                               name, bus.o_ready, bus.o_busy);
        end
        consume();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL %s after_consume got valid=%b ready=%b busy=%b want 0 1 0",
                               name, bus.o_valid, bus.o_ready, bus.o_busy);
        end
        $display("%s: a=%h b=%h uns=%b less=%b eq=%b lat=%0d", name, a, b, uns,
                 exp_less, exp_eq, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        send_and_wait(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        checks++;
        if (lat !== LAT_EARLY) begin
            errors++; $display("FAIL bp_latency got %0d want %0d", lat, LAT_EARLY);
        end
        for (int i = 0; i < 3; i++) begin
            bus.i_valid    = 1'b1;
            bus.i_rs1_data = 32'h0000_0005;
            bus.i_rs2_data = 32'h0000_0005;
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            checks++;
            if ({bus.o_valid, bus.o_br_less, bus.o_br_equal, bus.o_ready} !== 4'b1100) begin
                errors++;
                $display("FAIL bp_hold%0d got v/l/e/r=%b want 1100", i,
                         {bus.o_valid, bus.o_br_less, bus.o_br_equal, bus.o_ready});
            end
        end
        consume();
        @(posedge clk); #1;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_accept got busy=%b valid=%b want 0 0",
                               bus.o_busy, bus.o_valid);
        end
        $display("test_backpressure: held 3 cycles");
    endtask

    task automatic test_back_to_back();
        int lat;
        send_and_wait(32'h0000_0001, 32'h0000_0002, 1'b1, lat);
        // Offer the next request in the same cycle the result is consumed.
        bus.i_rs1_data    = 32'h8000_0000;
        bus.i_rs2_data    = 32'h7FFF_FFFF;
        bus.i_br_unsigned = 1'b0;
        bus.i_valid       = 1'b1;
        bus.i_ready       = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_idle_gap got busy=%b ready=%b want 0 1",
                               bus.o_busy, bus.o_ready);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.o_busy);
        end
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== LAT_EARLY || bus.o_br_less !== 1'b1 || bus.o_br_equal !== 1'b0) begin
            errors++; $display("FAIL b2b_result got lat=%0d less=%b eq=%b want %0d 1 0",
                               lat, bus.o_br_less, bus.o_br_equal, LAT_EARLY);
        end
        consume();
        $display("test_back_to_back: second request lat=%0d", lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.i_rs1_data    = 32'h8000_0010;
        bus.i_rs2_data    = 32'h8000_0011;
        bus.i_br_unsigned = 1'b0;
        bus.i_valid       = 1'b1;
        @(posedge clk); #1;          // accept edge
        bus.i_valid = 1'b0;
        @(posedge clk); #2;          // now in the 2nd CMP cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_br_less, bus.o_br_equal, bus.o_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_mid got %b want 10000",
                     {bus.o_ready, bus.o_valid, bus.o_br_less, bus.o_br_equal, bus.o_busy});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_leak got valid=%b busy=%b want 0 0",
                               bus.o_valid, bus.o_busy);
        end
        send_and_wait(32'h1234_5678, 32'h1234_5678, 1'b0, lat);
        checks++;
        if (lat !== 4 || bus.o_br_less !== 1'b0 || bus.o_br_equal !== 1'b1) begin
            errors++; $display("FAIL reset_fresh got lat=%0d less=%b eq=%b want 4 0 1",
                               lat, bus.o_br_less, bus.o_br_equal);
        end
        consume();
        $display("test_reset_mid: fresh request lat=%0d", lat);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        bus.i_valid       = 1'b0;
        bus.i_ready       = 1'b0;
        bus.i_rs1_data    = '0;
        bus.i_rs2_data    = '0;
        bus.i_br_unsigned = 1'b0;
        test_reset();
        test_case("signed",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, LAT_EARLY);
        test_case("unsigned",  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, LAT_EARLY);
        test_case("equal_s",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 4);
        test_case("equal_u",   32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 4);
        test_case("late_diff", 32'h8000_0010, 32'h8000_0011, 1'b0, 1'b1, 1'b0, 4);
        test_case("late_gt_u", 32'h0000_0102, 32'h0000_0101, 1'b1, 1'b0, 1'b0, 4);
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
